// File: rtl/servo_pwm_capture_pkg.sv
// servo_pwm_pkg: shared state encoding and default sizing for the servo PWM blocks
package servo_pwm_pkg;
  localparam int CNT_W_DEF = 32;
  localparam int TIMEOUT_DEF = 100000000;
  typedef enum logic [1:0] {IDLE, ARMED, HIGH, LOW} state_t;
endpackage

// File: rtl/servo_pwm_capture_if.sv
// servo_pwm_capture_if: measurement result channel with valid/ready handshake and status flags
interface servo_pwm_capture_if #(parameter int CNT_W = 32);
  logic meas_valid;
  logic meas_ready;
  logic [CNT_W-1:0] high_count;
  logic [CNT_W-1:0] period_count;
  logic overrun;
  logic signal_lost;
  modport master (output meas_valid, high_count, period_count, overrun, signal_lost, input meas_ready);
  modport slave (input meas_valid, high_count, period_count, overrun, signal_lost, output meas_ready);
endinterface

// File: rtl/pwm_edge_sync.sv
// pwm_edge_sync: input synchronizer with edge detect; o_primed marks when pwm_s and its delay hold real samples
module pwm_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock_clk,
  input  logic reset_low,
  input  logic i_pwm,
  output logic o_pwm_s,
  output logic o_rise,
  output logic o_fall,
  output logic o_primed
);
  logic [SYNC_STAGES-1:0] r_sync;
  logic r_pwm_d;
  logic [SYNC_STAGES:0] r_fill;
  always_ff @(posedge clock_clk or negedge reset_low) begin
    if (!reset_low) begin
      r_sync <= '0;
      r_pwm_d <= 1'b0;
      r_fill <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_pwm};
      r_pwm_d <= r_sync[SYNC_STAGES-1];
      r_fill <= {r_fill[SYNC_STAGES-1:0], 1'b1};
    end
  end
  assign o_pwm_s = r_sync[SYNC_STAGES-1];
  assign o_rise = o_pwm_s & ~r_pwm_d;
  assign o_fall = ~o_pwm_s & r_pwm_d;
  assign o_primed = r_fill[SYNC_STAGES];
endmodule

// File: rtl/servo_pwm_capture.sv
// servo_pwm_capture: measures high time and period of a PWM input and hands results out on valid/ready
module servo_pwm_capture
  import servo_pwm_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int SYNC_STAGES = 2
) (
  input logic clock_clk,
  input logic reset_low,
  input logic pwm_in,
  servo_pwm_capture_if.master m
);
  localparam logic [CNT_W-1:0] LP_TIMEOUT = CNT_W'(TIMEOUT);
  state_t r_state, w_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next, r_hold, r_high, r_period;
  logic r_valid, r_overrun, r_lost;
  logic w_pwm_s, w_rise, w_fall, w_primed;
  logic w_timeout, w_done, w_capture, w_accept;
  pwm_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clock_clk(clock_clk),
    .reset_low(reset_low),
    .i_pwm(pwm_in),
    .o_pwm_s(w_pwm_s),
    .o_rise(w_rise),
    .o_fall(w_fall),
    .o_primed(w_primed)
  );
  assign w_timeout = (r_state != IDLE) && (r_cnt == LP_TIMEOUT) && !w_rise && !w_fall;
  assign w_done = (r_state == LOW) && w_rise;
  assign w_capture = (r_state == HIGH) && w_fall;
  assign w_accept = r_valid && m.meas_ready;
  always_comb begin
    w_next = r_state;
    if (w_timeout) w_next = IDLE;
    else unique case (r_state)
      IDLE:  w_next = (w_primed && !w_pwm_s) ? ARMED : IDLE;
      ARMED: w_next = w_rise ? HIGH : ARMED;
      HIGH:  w_next = w_fall ? LOW : HIGH;
      LOW:   w_next = w_rise ? HIGH : LOW;
    endcase
    w_cnt_next = (w_timeout || r_state == IDLE) ? '0 :
                 w_rise ? CNT_W'(1) :
                 (r_cnt == LP_TIMEOUT) ? r_cnt : r_cnt + 1'b1;
  end
  always_ff @(posedge clock_clk or negedge reset_low) begin
    if (!reset_low) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_hold <= '0;
    end else begin
      r_state <= w_next;
      r_cnt <= w_cnt_next;
      if (w_capture) r_hold <= r_cnt;
    end
  end
  // A completion coinciding with an accept replaces the data cleanly; one against a stalled consumer overruns.
  always_ff @(posedge clock_clk or negedge reset_low) begin
    if (!reset_low) begin
      r_valid <= 1'b0;
      r_high <= '0;
      r_period <= '0;
      r_overrun <= 1'b0;
      r_lost <= 1'b0;
    end else begin
      if (w_done) begin
        r_valid <= 1'b1;
        r_high <= r_hold;
        r_period <= r_cnt;
      end else if (w_accept) r_valid <= 1'b0;
      r_overrun <= (w_done && r_valid && !m.meas_ready) ? 1'b1 : w_accept ? 1'b0 : r_overrun;
      r_lost <= w_timeout ? 1'b1 : (r_state == ARMED && w_rise) ? 1'b0 : r_lost;
    end
  end
  assign m.meas_valid = r_valid;
  assign m.high_count = r_high;
  assign m.period_count = r_period;
  assign m.overrun = r_overrun;
  assign m.signal_lost = r_lost;
endmodule

// File: tb/tb_servo_pwm_capture.sv
// tb_servo_pwm_capture: directed table-driven and sequence checks of servo_pwm_capture at TIMEOUT=1000
module tb_servo_pwm_capture;
  logic clk = 1'b0;
  logic reset_low = 1'b0;
  logic pwm_in = 1'b0;
  int checks = 0;
  int errors = 0;
  typedef struct {int hi; int lo; int exp_h; int exp_p;} vec_t;
  typedef struct {logic [31:0] h; logic [31:0] p; logic ov;} res_t;
  vec_t vecs[5];
  res_t q[$];
  servo_pwm_capture_if #(.CNT_W(32)) bus ();
  servo_pwm_capture #(.CNT_W(32), .TIMEOUT(1000), .SYNC_STAGES(2)) dut (
    .clock_clk(clk),
    .reset_low(reset_low),
    .pwm_in(pwm_in),
    .m(bus)
  );
  always #5 clk = ~clk;
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (bus.meas_valid && bus.meas_ready) q.push_back('{bus.high_count, bus.period_count, bus.overrun});
    end
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic drive(input logic p, input int n);
    repeat (n) begin
      @(negedge clk);
      pwm_in = p;
    end
  endtask
  task automatic run_periods(input int hi, input int lo, input int n);
    repeat (n) begin
      drive(1'b1, hi);
      drive(1'b0, lo);
    end
  endtask
  task automatic trail(input int hi);
    drive(1'b1, hi);
    drive(1'b0, 10);
  endtask
  task automatic do_reset(input logic p, input logic rdy);
    @(negedge clk);
    reset_low = 1'b0;
    pwm_in = p;
    bus.meas_ready = rdy;
    repeat (3) @(negedge clk);
    reset_low = 1'b1;
    q.delete();
  endtask
  task automatic check_q(input string nm, input int n, input int h, input int p, input logic ov);
    chk({nm, " count"}, q.size(), n);
    for (int i = 0; i < q.size() && i < n; i++) begin
      chk({nm, " high"}, q[i].h, h);
      chk({nm, " period"}, q[i].p, p);
      chk({nm, " overrun"}, q[i].ov, ov);
    end
    q.delete();
  endtask
  task automatic resume(input string nm);
    drive(1'b0, 20);
    @(negedge clk);
    pwm_in = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #2 chk({nm, " lost before rise"}, bus.signal_lost, 1);
    @(negedge clk);
    #2 chk({nm, " lost cleared"}, bus.signal_lost, 0);
    drive(1'b1, 46);
    drive(1'b0, 150);
    run_periods(50, 150, 2);
    trail(50);
    check_q({nm, " resume"}, 3, 50, 200, 1'b0);
  endtask
  initial begin
    bus.meas_ready = 1'b0;
    vecs[0] = '{70, 30, 70, 100};
    vecs[1] = '{1, 1, 1, 2};
    vecs[2] = '{5, 1, 5, 6};
    vecs[3] = '{1, 5, 1, 6};
    vecs[4] = '{200, 55, 200, 255};
    do_reset(1'b0, 1'b1);
    @(negedge clk);
    #2;
    chk("reset valid", bus.meas_valid, 0);
    chk("reset high", bus.high_count, 0);
    chk("reset period", bus.period_count, 0);
    chk("reset overrun", bus.overrun, 0);
    chk("reset lost", bus.signal_lost, 0);
    for (int v = 0; v < 5; v++) begin
      do_reset(1'b0, 1'b1);
      drive(1'b0, 10);
      run_periods(vecs[v].hi, vecs[v].lo, 4);
      trail(vecs[v].hi);
      check_q($sformatf("vec%0d", v), 4, vecs[v].exp_h, vecs[v].exp_p, 1'b0);
    end
    do_reset(1'b1, 1'b1);
    drive(1'b1, 20);
    drive(1'b0, 60);
    run_periods(40, 60, 3);
    trail(40);
    check_q("high at reset", 3, 40, 100, 1'b0);
    do_reset(1'b0, 1'b0);
    drive(1'b0, 10);
    run_periods(70, 30, 3);
    drive(1'b1, 70);
    drive(1'b0, 10);
    #2;
    chk("ovr pending valid", bus.meas_valid, 1);
    chk("ovr pending flag", bus.overrun, 1);
    @(negedge clk);
    bus.meas_ready = 1'b1;
    @(negedge clk);
    bus.meas_ready = 1'b0;
    #2;
    chk("ovr valid after accept", bus.meas_valid, 0);
    chk("ovr flag after accept", bus.overrun, 0);
    check_q("ovr accept", 1, 70, 100, 1'b1);
    do_reset(1'b0, 1'b0);
    drive(1'b0, 10);
    run_periods(70, 30, 1);
    run_periods(50, 60, 1);
    @(negedge clk);
    pwm_in = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.meas_ready = 1'b1;
    @(negedge clk);
    bus.meas_ready = 1'b0;
    #2;
    chk("same valid", bus.meas_valid, 1);
    chk("same overrun", bus.overrun, 0);
    chk("same high", bus.high_count, 50);
    chk("same period", bus.period_count, 110);
    check_q("same old", 1, 70, 100, 1'b0);
    @(negedge clk);
    bus.meas_ready = 1'b1;
    @(negedge clk);
    bus.meas_ready = 1'b0;
    #2 check_q("same new", 1, 50, 110, 1'b0);
    do_reset(1'b0, 1'b1);
    drive(1'b0, 10);
    run_periods(70, 30, 2);
    drive(1'b1, 70);
    drive(1'b0, 932);
    @(negedge clk);
    #2 chk("low lost at 999", bus.signal_lost, 0);
    @(negedge clk);
    #2 chk("low lost at 1000", bus.signal_lost, 1);
    check_q("low before stall", 2, 70, 100, 1'b0);
    resume("low");
    do_reset(1'b0, 1'b1);
    drive(1'b0, 10);
    run_periods(70, 30, 2);
    drive(1'b1, 1002);
    @(negedge clk);
    #2 chk("high lost at 999", bus.signal_lost, 0);
    @(negedge clk);
    #2 chk("high lost at 1000", bus.signal_lost, 1);
    check_q("high before stall", 2, 70, 100, 1'b0);
    drive(1'b0, 150);
    resume("high");
    do_reset(1'b0, 1'b0);
    drive(1'b0, 10);
    run_periods(70, 30, 1);
    drive(1'b1, 30);
    #2 chk("arst valid before", bus.meas_valid, 1);
    #1 reset_low = 1'b0;
    #1;
    chk("arst valid", bus.meas_valid, 0);
    chk("arst high", bus.high_count, 0);
    chk("arst period", bus.period_count, 0);
    chk("arst overrun", bus.overrun, 0);
    @(negedge clk);
    reset_low = 1'b1;
    bus.meas_ready = 1'b1;
    q.delete();
    drive(1'b1, 40);
    drive(1'b0, 30);
    run_periods(70, 30, 2);
    trail(70);
    check_q("arst after", 2, 70, 100, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/servo_pwm_capture.md
Name: servo_pwm_capture

Overview:
Receive-side counterpart of the team's servo PWM generator. Measures the high time and period of an incoming PWM/pulse train in clock_clk cycles and presents each completed measurement on a valid/ready interface. Used for loop-back checks of the generated servo/stepper drive and for reading external PWM sources (RC receiver, sensor echo). Flags loss of signal via a timeout.

Parameters:
CNT_W, 32, width of the high and period counters and result fields
TIMEOUT, 100000000, cycles without a qualifying edge before signal_lost; must satisfy 2 <= TIMEOUT < 2^CNT_W
SYNC_STAGES, 2, flops in the pwm_in synchronizer; minimum 2

Ports:
clock_clk  in  1  system clock; the only clock
reset_low  in  1  asynchronous, active-low reset
pwm_in  in  1  asynchronous PWM input
meas_valid  out  1  measurement available
meas_ready  in  1  consumer accepts the measurement when meas_valid && meas_ready
high_count  out  CNT_W  high time of the last completed period, in cycles
period_count  out  CNT_W  rising-to-rising period, in cycles
overrun  out  1  at least one measurement was overwritten before acceptance
signal_lost  out  1  timeout has occurred; no valid edge since

Behaviour:
- Reset (async assert, sync release): sync flops=0, edge reg=0, state=IDLE, cnt=0, meas_valid=0, high_count=0, period_count=0, overrun=0, signal_lost=0.
- pwm_in passes through SYNC_STAGES flops, giving pwm_s. rise = pwm_s & ~pwm_s_d. fall = ~pwm_s & pwm_s_d.
- Counter cnt: loads 1 on the cycle after a rise. Otherwise it increments each cycle. It clears to 0 on entry to IDLE.
- Edge-to-edge distance of N cycles gives an exact value N. Input-to-detect latency is SYNC_STAGES+1 cycles and cancels out because both edges see the same delay.
- States:
  - IDLE: wait for pwm_s==0, then go to ARMED. This guarantees the first measured pulse is whole, including when the input is high at reset release.
  - ARMED: on rise, go to HIGH.
  - HIGH: on fall, capture h=cnt into a hold register and go to LOW.
  - LOW: on rise, the measurement completes with high=h and period=cnt. Go to HIGH.
  - A rise in HIGH or a fall in ARMED/LOW cannot occur on a clean input. Ignore it with no state change.
- Result timing: on the cycle after completion, high_count and period_count load and meas_valid goes to 1.
- Handshake:
  - meas_valid stays 1 and the data stays stable until a cycle with meas_ready=1.
  - An accept with no new completion on the same cycle clears meas_valid on the next cycle.
  - A completion and an accept on the same cycle load the new data with meas_valid still 1 and no overrun.
  - A completion while valid is pending and not accepted loads the new data (latest wins) and sets overrun=1.
  - overrun clears on the next accept cycle. The accept cycle presents the data together with its overrun flag.
- Timeout:
  - Trigger: in any state other than IDLE, cnt reaching TIMEOUT with no rise or fall on that cycle.
  - Effect: signal_lost=1, state goes to IDLE, cnt=0, and any half-done measurement is discarded.
  - A pending meas_valid is unaffected.
  - Timeout also covers an input stuck high (HIGH state) and stuck low (LOW or ARMED state).
  - signal_lost clears on the next rise seen in ARMED.
- cnt never exceeds TIMEOUT, so no wrap is possible.
- An async reset mid-pulse aborts everything and restarts from IDLE. No partial result is ever emitted.

Decomposition:
- Package servo_pwm_pkg:
  - state enum {IDLE, ARMED, HIGH, LOW}
  - default CNT_W
  - default TIMEOUT constant (shared with the generator's totalTime)
- Sub-module pwm_edge_sync: SYNC_STAGES synchronizer plus registered delay, outputting pwm_s, rise and fall. It is reused by future encoder/endstop inputs.
- Top-level holds the FSM, counter, hold register and output handshake.

Test Plan:
- TIMEOUT=1000. Drive 70 cycles high / 30 low, repeated, with meas_ready=1 → first meas_valid after the second rise. Every result is high_count=70, period_count=100, overrun=0.
- Hold pwm_in=1 through reset release, then drop it after 20 cycles and run 40/100 → no result for the truncated pulse. The first result is 40/100.
- meas_ready=0 across three completed 70/100 periods, then meas_ready=1 for one cycle → exactly one accept with overrun=1 and data 70/100. Then overrun=0 and meas_valid=0 until the next completion.
- Completion on the same cycle as an accept → meas_valid stays 1, new data is loaded, overrun=0.
- Stop toggling with pwm_in low, TIMEOUT=1000 → signal_lost=1 exactly 1000 cycles after the last rise-detect. Resume at 50/200 → signal_lost clears on the first rise and the first result is 50/200. Repeat with pwm_in stuck high.
- Assert reset_low mid-high with meas_valid=1 → all outputs return to 0 at once, and the next result is only a complete 70/100.
